// File: rtl/iexu_issue_arbiter.sv
// Round-robin issue arbiter that feeds one shared integer execution unit.
// Pipeline: S1 operand register drives the IEXU; S2 result register sends results to writeback with a valid/ready handshake.
package iexu_pkg;
  typedef enum logic [2:0] {
    IEXU_ADD = 3'd0,
    IEXU_SUB = 3'd1,
    IEXU_AND = 3'd2,
    IEXU_OR  = 3'd3,
    IEXU_XOR = 3'd4,
    IEXU_SLL = 3'd5,
    IEXU_SRL = 3'd6,
    IEXU_SRA = 3'd7
  } iexu_conf_t;

  localparam iexu_conf_t ADD_CONF = IEXU_ADD;
endpackage

module iexu_issue_arbiter
  import iexu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int TAGW = 4,
  localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  iexu_conf_t       req_conf [NREQ],
  input  logic [XLEN-1:0]  req_a [NREQ],
  input  logic [XLEN-1:0]  req_b [NREQ],
  input  logic [TAGW-1:0]  req_tag [NREQ],
  output iexu_conf_t       exu_conf,
  output logic [XLEN-1:0]  exu_a,
  output logic [XLEN-1:0]  exu_b,
  input  logic [XLEN-1:0]  exu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [XLEN-1:0]  res_data,
  output logic [TAGW-1:0]  res_tag,
  output logic [SRCW-1:0]  res_src
);

  function automatic logic [SRCW-1:0] wrap_idx(input logic [SRCW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return SRCW'(s);
  endfunction

  logic [SRCW-1:0] rr_ptr;
  logic            vld_p1;
  iexu_conf_t      conf_p1;
  logic [XLEN-1:0] a_p1;
  logic [XLEN-1:0] b_p1;
  logic [TAGW-1:0] tag_p1;
  logic [SRCW-1:0] src_p1;
  logic            vld_p2;
  logic [XLEN-1:0] data_p2;
  logic [TAGW-1:0] tag_p2;
  logic [SRCW-1:0] src_p2;

  logic            s2_free;
  logic            s1_adv;
  logic            s1_can_accept;
  logic            gnt_vld;
  logic [SRCW-1:0] gnt_idx;
  logic            accept;

  assign s2_free       = !vld_p2 || res_ready;
  assign s1_adv        = vld_p1 && s2_free;
  assign s1_can_accept = (!vld_p1 || s2_free) && !flush && !rst;
  assign accept        = gnt_vld && s1_can_accept;

  // Arbitration: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_vld && req_valid[wrap_idx(rr_ptr, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap_idx(rr_ptr, k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  // S1 operand register and S2 result register
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      conf_p1 <= ADD_CONF;
      a_p1    <= '0;
      b_p1    <= '0;
      tag_p1  <= '0;
      src_p1  <= '0;
      data_p2 <= '0;
      tag_p2  <= '0;
      src_p2  <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (s1_adv) begin
        data_p2 <= exu_result;
        tag_p2  <= tag_p1;
        src_p2  <= src_p1;
        vld_p2  <= 1'b1;
      end else if (vld_p2 && res_ready) begin
        vld_p2 <= 1'b0;
      end

      if (accept) begin
        conf_p1 <= req_conf[gnt_idx];
        a_p1    <= req_a[gnt_idx];
        b_p1    <= req_b[gnt_idx];
        tag_p1  <= req_tag[gnt_idx];
        src_p1  <= gnt_idx;
        vld_p1  <= 1'b1;
        rr_ptr  <= wrap_idx(gnt_idx, 1);
      end else if (s1_adv) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // IEXU drive and writeback outputs
  assign exu_conf  = conf_p1;
  assign exu_a     = a_p1;
  assign exu_b     = b_p1;
  assign res_valid = vld_p2;
  assign res_data  = data_p2;
  assign res_tag   = tag_p2;
  assign res_src   = src_p2;

endmodule

// File: tb/tb_iexu_issue_arbiter.sv
// Bench for iexu_issue_arbiter: operation vectors, directed pipeline sequences,
// and random traffic against a queue-based model of the two-slot pipeline.
module tb_iexu_issue_arbiter;
  import iexu_pkg::*;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // NREQ=2 instance
  logic        rst, flush, res_ready, res_valid;
  logic [1:0]  req_valid, req_ready;
  iexu_conf_t  r_conf [2];
  logic [31:0] r_a [2];
  logic [31:0] r_b [2];
  logic [3:0]  r_tag [2];
  iexu_conf_t  exu_conf;
  logic [31:0] exu_a, exu_b, exu_result, res_data;
  logic [3:0]  res_tag;
  logic [0:0]  res_src;

  // NREQ=1 instance
  logic        rst1, flush1, rr1, rv1;
  logic [0:0]  v1, rdy1, rs1;
  iexu_conf_t  c1 [1];
  logic [31:0] a1 [1];
  logic [31:0] b1 [1];
  logic [3:0]  t1 [1];
  iexu_conf_t  e1_conf;
  logic [31:0] e1_a, e1_b, e1_res, rd1;
  logic [3:0]  rt1;

  function automatic logic [31:0] iexu_f(input iexu_conf_t c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      IEXU_SUB: iexu_f = a - b;
      IEXU_AND: iexu_f = a & b;
      IEXU_OR:  iexu_f = a | b;
      IEXU_XOR: iexu_f = a ^ b;
      IEXU_SLL: iexu_f = a << b[4:0];
      IEXU_SRL: iexu_f = a >> b[4:0];
      IEXU_SRA: iexu_f = 32'($signed(a) >>> b[4:0]);
      default:  iexu_f = a + b;
    endcase
  endfunction

  assign exu_result = iexu_f(exu_conf, exu_a, exu_b);
  assign e1_res     = iexu_f(e1_conf, e1_a, e1_b);

  iexu_issue_arbiter #(.NREQ(2), .XLEN(32), .TAGW(4)) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_conf(r_conf), .req_a(r_a), .req_b(r_b), .req_tag(r_tag),
    .exu_conf(exu_conf), .exu_a(exu_a), .exu_b(exu_b), .exu_result(exu_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .res_src(res_src)
  );

  iexu_issue_arbiter #(.NREQ(1), .XLEN(32), .TAGW(4)) u1 (
    .clk(clk), .rst(rst1), .flush(flush1),
    .req_valid(v1), .req_ready(rdy1),
    .req_conf(c1), .req_a(a1), .req_b(b1), .req_tag(t1),
    .exu_conf(e1_conf), .exu_a(e1_a), .exu_b(e1_b), .exu_result(e1_res),
    .res_valid(rv1), .res_ready(rr1),
    .res_data(rd1), .res_tag(rt1), .res_src(rs1)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    iexu_conf_t  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vec [10];

  // Reference model: in-order queue of accepted ops; an op accepted at
  // edge N is visible at S2 from edge N+1 onward, and the pipeline holds two.
  typedef struct {
    logic [31:0] d;
    logic [3:0]  tag;
    int          src;
    int          stamp;
    iexu_conf_t  c;
    logic [31:0] a;
    logic [31:0] b;
  } item_t;
  item_t q[$];
  int    rr_m = 0;
  int    e_m = 0;
  bit    mon_en = 1'b0;

  always @(negedge clk) begin : mon
    bit         vis, found, can, lvis;
    int         g, idx;
    logic [1:0] er;
    item_t      it;
    if (mon_en) begin
      vis = (q.size() > 0) && (q[0].stamp + 2 <= e_m);
      chk("mon_res_valid", 64'(res_valid), 64'(vis));
      if (vis) begin
        chk("mon_res_data", 64'(res_data), 64'(q[0].d));
        chk("mon_res_tag", 64'(res_tag), 64'(q[0].tag));
        chk("mon_res_src", 64'(res_src), 64'(q[0].src));
      end
      if (q.size() > 0) begin
        lvis = (q[q.size()-1].stamp + 2 <= e_m);
        if (!lvis) begin
          chk("mon_exu_a", 64'(exu_a), 64'(q[q.size()-1].a));
          chk("mon_exu_b", 64'(exu_b), 64'(q[q.size()-1].b));
          chk("mon_exu_conf", 64'(exu_conf), 64'(q[q.size()-1].c));
        end
      end
      found = 1'b0;
      g = 0;
      for (int k = 0; k < 2; k++) begin
        idx = (rr_m + k) % 2;
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          g = idx;
        end
      end
      can = !rst && !flush && !(q.size() == 2 && !res_ready);
      er = (can && found) ? 2'(1 << g) : 2'b00;
      chk("mon_req_ready", 64'(req_ready), 64'(er));
      if (rst) begin
        q.delete();
        rr_m = 0;
      end else if (flush) begin
        q.delete();
      end else begin
        if (vis && res_ready) void'(q.pop_front());
        if (can && found) begin
          it.d = iexu_f(r_conf[g], r_a[g], r_b[g]);
          it.tag = r_tag[g];
          it.src = g;
          it.stamp = e_m;
          it.c = r_conf[g];
          it.a = r_a[g];
          it.b = r_b[g];
          q.push_back(it);
          rr_m = (g + 1) % 2;
        end
      end
      e_m++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_op(input int i, input vec_t v, input logic [3:0] t);
    r_conf[i] = v.c;
    r_a[i] = v.a;
    r_b[i] = v.b;
    r_tag[i] = t;
  endtask

  int acc, del;
  logic [7:0] bp_rdy;

  initial begin
    vec[0] = '{IEXU_ADD, 32'd5,          32'd3,         32'd8};
    vec[1] = '{IEXU_SUB, 32'd10,         32'd4,         32'd6};
    vec[2] = '{IEXU_XOR, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F};
    vec[3] = '{IEXU_SRA, 32'hF000_0000, 32'd4,         32'hFF00_0000};
    vec[4] = '{IEXU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0};
    vec[5] = '{IEXU_OR,  32'h0000_F000, 32'h0000_000F, 32'h0000_F00F};
    vec[6] = '{IEXU_SLL, 32'd1,          32'd4,         32'h0000_0010};
    vec[7] = '{IEXU_SRL, 32'h0000_0080, 32'd3,         32'h0000_0010};
    vec[8] = '{IEXU_SUB, 32'd0,          32'd1,         32'hFFFF_FFFF};
    vec[9] = '{IEXU_SLL, 32'd1,          32'h0000_0021, 32'd2};

    rst = 1'b1; flush = 1'b0; res_ready = 1'b1; req_valid = 2'b00;
    for (int i = 0; i < 2; i++) set_op(i, vec[0], 4'd0);
    rst1 = 1'b1; flush1 = 1'b0; rr1 = 1'b1; v1 = 1'b0;
    c1[0] = IEXU_ADD; a1[0] = '0; b1[0] = '0; t1[0] = '0;

    // Reset held two cycles with a pending request, then one add
    tick();
    mon_en = 1'b1;
    set_op(0, vec[0], 4'd2);
    req_valid = 2'b01;
    settle();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_tag", 64'(res_tag), 64'd0);
    chk("rst_res_src", 64'(res_src), 64'd0);
    chk("rst_exu_conf", 64'(exu_conf), 64'(ADD_CONF));
    chk("rst_exu_a", 64'(exu_a), 64'd0);
    chk("rst_exu_b", 64'(exu_b), 64'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("single_ready", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b00;
    settle();
    chk("single_exu_a", 64'(exu_a), 64'd5);
    chk("single_exu_b", 64'(exu_b), 64'd3);
    chk("single_early_valid", 64'(res_valid), 64'd0);
    tick();
    settle();
    chk("single_res_valid", 64'(res_valid), 64'd1);
    chk("single_res_data", 64'(res_data), 64'd8);
    chk("single_res_tag", 64'(res_tag), 64'd2);
    chk("single_res_src", 64'(res_src), 64'd0);
    tick();

    // Operation vectors through requester 0
    for (int i = 0; i < 10; i++) begin
      set_op(0, vec[i], 4'(i));
      req_valid = 2'b01;
      settle();
      chk("vec_ready", 64'(req_ready), 64'b01);
      tick();
      req_valid = 2'b00;
      tick();
      settle();
      chk("vec_valid", 64'(res_valid), 64'd1);
      chk("vec_data", 64'(res_data), 64'(vec[i].exp));
      chk("vec_tag", 64'(res_tag), 64'(i));
    end
    tick();

    // Round robin with both requesters always valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_op(0, vec[1], 4'd1);
    set_op(1, vec[2], 4'd3);
    req_valid = 2'b11;
    res_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c == 12) req_valid = 2'b00;
      settle();
      if (c < 12) chk("rr_grant", 64'(req_ready), (c % 2 == 0) ? 64'b01 : 64'b10);
      if (c >= 2) begin
        chk("rr_res_valid", 64'(res_valid), 64'd1);
        chk("rr_res_data", 64'(res_data), (c % 2 == 0) ? 64'd6 : 64'h0F);
        chk("rr_res_src", 64'(res_src), 64'(c % 2));
      end
      tick();
    end

    // Backpressure: stream on requester 1, writeback stalls for 3 cycles
    set_op(1, vec[3], 4'd5);
    bp_rdy = 8'b1110_0011;
    acc = 0;
    del = 0;
    for (int c = 0; c < 12; c++) begin
      res_ready = !(c >= 2 && c <= 4);
      req_valid = (c < 8) ? 2'b10 : 2'b00;
      settle();
      if (c < 8) chk("bp_ready", 64'(req_ready), 64'({bp_rdy[c], 1'b0}));
      if (c >= 2 && c <= 5) begin
        chk("bp_hold_valid", 64'(res_valid), 64'd1);
        chk("bp_hold_data", 64'(res_data), 64'hFF00_0000);
        chk("bp_hold_exu_a", 64'(exu_a), 64'hF000_0000);
      end
      if (req_valid[1] && req_ready[1]) acc++;
      if (res_valid && res_ready) del++;
      tick();
    end
    chk("bp_accepted", 64'(acc), 64'd5);
    chk("bp_delivered", 64'(del), 64'd5);

    // Flush with both stages occupied
    set_op(0, vec[0], 4'd6);
    req_valid = 2'b01;
    res_ready = 1'b0;
    settle();
    chk("fl_fill0", 64'(req_ready), 64'b01);
    tick();
    settle();
    chk("fl_fill1", 64'(req_ready), 64'b01);
    tick();
    flush = 1'b1;
    res_ready = 1'b1;
    settle();
    chk("fl_ready", 64'(req_ready), 64'd0);
    chk("fl_valid_before", 64'(res_valid), 64'd1);
    tick();
    flush = 1'b0;
    set_op(1, vec[1], 4'd7);
    req_valid = 2'b11;
    settle();
    chk("fl_valid_after", 64'(res_valid), 64'd0);
    chk("fl_rr_kept", 64'(req_ready), 64'b10);
    tick();
    req_valid = 2'b00;
    settle();
    chk("fl_s1_empty", 64'(res_valid), 64'd0);
    tick();
    settle();
    chk("fl_next_valid", 64'(res_valid), 64'd1);
    chk("fl_next_data", 64'(res_data), 64'd6);
    chk("fl_next_tag", 64'(res_tag), 64'd7);
    chk("fl_next_src", 64'(res_src), 64'd1);
    tick();

    // Reset with two subtracts in flight
    set_op(0, vec[1], 4'd9);
    req_valid = 2'b01;
    res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    settle();
    chk("rm_ready", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b0;
    set_op(0, vec[5], 4'd8);
    set_op(1, vec[2], 4'd3);
    req_valid = 2'b11;
    res_ready = 1'b1;
    settle();
    chk("rm_res_valid", 64'(res_valid), 64'd0);
    chk("rm_exu_conf", 64'(exu_conf), 64'(ADD_CONF));
    chk("rm_exu_a", 64'(exu_a), 64'd0);
    chk("rm_grant0", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b00;
    settle();
    chk("rm_no_stale", 64'(res_valid), 64'd0);
    tick();
    settle();
    chk("rm_next_valid", 64'(res_valid), 64'd1);
    chk("rm_next_data", 64'(res_data), 64'h0000_F00F);
    chk("rm_next_tag", 64'(res_tag), 64'd8);
    chk("rm_next_src", 64'(res_src), 64'd0);
    tick();

    // Single requester: and/or/sll/srl back to back
    settle();
    chk("n1_rst_valid", 64'(rv1), 64'd0);
    chk("n1_rst_ready", 64'(rdy1), 64'd0);
    tick();
    rst1 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        v1 = 1'b1;
        c1[0] = vec[4+c].c;
        a1[0] = vec[4+c].a;
        b1[0] = vec[4+c].b;
        t1[0] = 4'(c);
      end else begin
        v1 = 1'b0;
      end
      settle();
      if (c < 4) chk("n1_ready", 64'(rdy1), 64'd1);
      if (c >= 2) begin
        chk("n1_valid", 64'(rv1), 64'd1);
        chk("n1_data", 64'(rd1), 64'(vec[4+c-2].exp));
        chk("n1_tag", 64'(rt1), 64'(c - 2));
        chk("n1_src", 64'(rs1), 64'd0);
      end
      tick();
    end

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 31) == 0);
      res_ready = ($urandom_range(0, 3) != 0);
      req_valid = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        r_conf[i] = iexu_conf_t'(3'($urandom));
        r_a[i] = $urandom;
        r_b[i] = $urandom;
        r_tag[i] = 4'($urandom);
      end
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    req_valid = 2'b00;
    res_ready = 1'b1;
    tick();
    tick();
    tick();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
